// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks a PC through a combinational ROM and
// presents one registered instruction slot to decode with a valid/ready handshake.
module fetch_ctrl #(
  parameter logic [7:0] START_ADDR = 8'h00,
  parameter logic [7:0] END_ADDR   = 8'h0F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  input  logic        branch_valid,
  input  logic [7:0]  branch_target,
  output logic [15:0] instr,
  output logic [7:0]  instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  state_t     state;
  logic [7:0] pc;
  logic       xfer;
  logic       slot_free;

  assign rom_addr  = pc;
  assign xfer      = instr_valid & instr_ready;
  assign slot_free = ~instr_valid | xfer;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= START_ADDR;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      // Decode consumed the entry, so it counts even when a branch flushes the slot.
      if (xfer && fetch_count != 16'hFFFF)
        fetch_count <= fetch_count + 16'd1;

      if (branch_valid) begin
        pc          <= branch_target;
        instr_valid <= 1'b0;
        halted      <= 1'b0;
        state       <= run ? FETCH : IDLE;
      end else begin
        // Drain by default; a capture below re-asserts valid in the same cycle.
        if (xfer)
          instr_valid <= 1'b0;
        case (state)
          IDLE: begin
            if (run)
              state <= FETCH;
          end
          FETCH: begin
            if (!run) begin
              state <= IDLE;
            end else if (slot_free) begin
              instr       <= rom_data;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              pc          <= pc + 8'd1;
              if (pc == END_ADDR) begin
                state  <= HALT;
                halted <= 1'b1;
              end
            end
          end
          HALT: begin
          end
          default: begin
            state  <= IDLE;
            halted <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: stream, backpressure, branch, halt restart,
// run gating, async reset and PC wrap on a second instance.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        run;
  logic        branch_valid;
  logic [7:0]  branch_target;
  logic        instr_ready;
  logic        rom_mode;

  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic [7:0]  d2_rom_addr;
  logic [15:0] d2_rom_data;
  logic [15:0] d2_instr;
  logic [7:0]  d2_instr_pc;
  logic        d2_instr_valid;
  logic        d2_halted;
  logic [15:0] d2_fetch_count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  assign rom_data    = rom_mode ? {8'hA5, rom_addr} : 16'hC000;
  assign d2_rom_data = 16'hC000;

  fetch_ctrl dut (
    .clk(clk), .reset(reset), .run(run), .rom_addr(rom_addr), .rom_data(rom_data),
    .branch_valid(branch_valid), .branch_target(branch_target), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .halted(halted), .fetch_count(fetch_count)
  );

  fetch_ctrl #(.START_ADDR(8'hFC), .END_ADDR(8'hFF)) dut2 (
    .clk(clk), .reset(reset), .run(run), .rom_addr(d2_rom_addr), .rom_data(d2_rom_data),
    .branch_valid(branch_valid), .branch_target(branch_target), .instr(d2_instr),
    .instr_pc(d2_instr_pc), .instr_valid(d2_instr_valid), .instr_ready(instr_ready),
    .halted(d2_halted), .fetch_count(d2_fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; branch_valid = 1'b0; branch_target = 8'h00;
    instr_ready = 1'b0; rom_mode = 1'b0;
    #3;
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 16'h0000);
    check("rst_pc", instr_pc, 0);
    check("rst_addr", rom_addr, 8'h00);
    check("rst_halted", halted, 0);
    check("rst_count", fetch_count, 0);
    check("rst_d2_addr", d2_rom_addr, 8'hFC);
    step(); step();
    reset = 1'b0;

    // Stream from 0x00 to END_ADDR, then halt
    run = 1'b1; instr_ready = 1'b1;
    step();
    check("str_idle_valid", instr_valid, 0);
    for (int i = 0; i < 16; i++) begin
      step();
      check("str_pc", instr_pc, i);
      check("str_valid", instr_valid, 1);
      check("str_instr", instr, 16'hC000);
      if (i == 0) check("d2_first_pc", d2_instr_pc, 8'hFC);
      if (i == 3) begin
        check("d2_last_pc", d2_instr_pc, 8'hFF);
        check("d2_halted", d2_halted, 1);
      end
    end
    check("str_halted", halted, 1);
    step();
    check("str_drain_valid", instr_valid, 0);
    check("str_count", fetch_count, 16);
    check("str_halt_hold", halted, 1);
    check("str_halt_addr", rom_addr, 8'h10);
    check("d2_wrap_addr", d2_rom_addr, 8'h00);
    step();
    check("halt_stays", halted, 1);

    // Restart out of HALT by branching to 0x0E
    branch_valid = 1'b1; branch_target = 8'h0E;
    step();
    branch_valid = 1'b0;
    check("hr_halted", halted, 0);
    check("hr_valid", instr_valid, 0);
    check("hr_addr", rom_addr, 8'h0E);
    step();
    check("hr_pc_e", instr_pc, 8'h0E);
    check("hr_halted_e", halted, 0);
    step();
    check("hr_pc_f", instr_pc, 8'h0F);
    check("hr_halted_f", halted, 1);
    step();
    check("hr_drain", instr_valid, 0);
    check("hr_count", fetch_count, 18);

    // Backpressure at instr_pc 0x04
    reset = 1'b1;
    step();
    reset = 1'b0; rom_mode = 1'b1;
    step();
    for (int i = 0; i < 5; i++) step();
    check("bp_pc4", instr_pc, 8'h04);
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_pc", instr_pc, 8'h04);
      check("bp_hold_instr", instr, 16'hA504);
      check("bp_hold_addr", rom_addr, 8'h05);
      check("bp_hold_valid", instr_valid, 1);
    end
    instr_ready = 1'b1;
    step();
    check("bp_resume_pc", instr_pc, 8'h05);
    check("bp_resume_instr", instr, 16'hA505);
    check("bp_count", fetch_count, 5);

    // Branch while 0x07 presented; coincident transfer still counts
    step(); step();
    check("br_pc7", instr_pc, 8'h07);
    branch_valid = 1'b1; branch_target = 8'h02;
    step();
    branch_valid = 1'b0;
    check("br_flush", instr_valid, 0);
    check("br_addr", rom_addr, 8'h02);
    check("br_count", fetch_count, 8);
    step();
    check("br_pc2", instr_pc, 8'h02);
    check("br_instr", instr, 16'hA502);

    // Run gating at instr_pc 0x03
    step();
    check("rg_pc3", instr_pc, 8'h03);
    run = 1'b0; instr_ready = 1'b0;
    step();
    check("rg_hold_pc", instr_pc, 8'h03);
    check("rg_hold_valid", instr_valid, 1);
    step();
    check("rg_hold_pc2", instr_pc, 8'h03);
    check("rg_hold_addr", rom_addr, 8'h04);
    instr_ready = 1'b1;
    step();
    check("rg_taken", instr_valid, 0);
    check("rg_no_capture_addr", rom_addr, 8'h04);
    run = 1'b1;
    step();
    check("rg_refetch_wait", instr_valid, 0);
    step();
    check("rg_pc4", instr_pc, 8'h04);
    check("rg_count", fetch_count, 10);

    // Asynchronous reset between edges while an entry is valid
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid", instr_valid, 0);
    check("ar_instr", instr, 16'h0000);
    check("ar_pc", instr_pc, 8'h00);
    check("ar_count", fetch_count, 0);
    check("ar_addr", rom_addr, 8'h00);
    check("ar_halted", halted, 0);
    step();
    reset = 1'b0;
    step();
    step();
    check("ar_first_pc", instr_pc, 8'h00);
    check("ar_first_instr", instr, 16'hA500);
    check("ar_first_valid", instr_valid, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
